// File: rtl/instr_sequencer_pkg.sv
// Shared encodings for the multicycle core sequencer and its control decoder.
package instr_sequencer_pkg;

    localparam int unsigned SEQ_STATE_W = 5;
    localparam int unsigned SEQ_MASK_W  = 8;

    typedef enum logic [SEQ_STATE_W-1:0] {
        S_FETCH    = 5'd0,
        S_DECODE   = 5'd1,
        S_ALU_RR   = 5'd2,
        S_WB_RC    = 5'd3,
        S_ALU_IMM  = 5'd4,
        S_WB_RB    = 5'd5,
        S_LHI_WB   = 5'd6,
        S_ADDR     = 5'd7,
        S_MEM_RD   = 5'd8,
        S_WB_LW    = 5'd9,
        S_MEM_WR   = 5'd10,
        S_BEQ_CMP  = 5'd11,
        S_BEQ_TAKE = 5'd12,
        S_JAL_LINK = 5'd13,
        S_JAL_TGT  = 5'd14,
        S_JLR_TGT  = 5'd15,
        S_LSM_INIT = 5'd16,
        S_LM_RD    = 5'd17,
        S_LM_WB    = 5'd18,
        S_SM_WR    = 5'd19,
        S_HALT     = 5'd20
    } state_e;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_JLR = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1100;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [1:0] CZ_ALWAYS = 2'b00;
    localparam logic [1:0] CZ_ZERO   = 2'b01;
    localparam logic [1:0] CZ_CARRY  = 2'b10;
    localparam logic [1:0] CZ_RSVD   = 2'b11;

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer <-> datapath signal bundle; master is the datapath side.
interface instr_sequencer_if #(
    parameter int unsigned STATE_W = 5
);
    logic [15:0]        ir;
    logic               compare;
    logic               carry_flag;
    logic               zero_flag;
    logic               mem_ready;
    logic [STATE_W-1:0] state_id;
    logic [2:0]         lsm_reg_idx;
    logic               lsm_addr_inc;
    logic               instr_done;
    logic               halted;
    logic               illegal;

    modport master (
        output ir, compare, carry_flag, zero_flag, mem_ready,
        input  state_id, lsm_reg_idx, lsm_addr_inc, instr_done, halted, illegal
    );

    modport slave (
        input  ir, compare, carry_flag, zero_flag, mem_ready,
        output state_id, lsm_reg_idx, lsm_addr_inc, instr_done, halted, illegal
    );
endinterface

// File: rtl/instr_sequencer_lsm_mask_walker.sv
// LM/SM register-mask walker: holds the live mask and presents its lowest set bit.
module lsm_mask_walker #(
    parameter int unsigned MASK_W = 8,
    parameter int unsigned IDX_W  = $clog2(MASK_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [MASK_W-1:0] load_mask_i,
    input  logic              advance_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              empty_o,
    output logic              last_o
);
    logic [MASK_W-1:0] mask_q, mask_d, remain;
    logic [IDX_W-1:0]  idx_q, idx_d;

    assign remain = mask_q & ~(MASK_W'(1) << idx_q);

    always_comb begin
        mask_d = mask_q;
        if (load_i) begin
            mask_d = load_mask_i;
        end else if (advance_i) begin
            mask_d = remain;
        end
    end

    // Index is encoded from the next mask so it registers alongside it.
    always_comb begin
        idx_d = '0;
        for (int unsigned i = MASK_W; i > 0; i--) begin
            if (mask_d[i-1]) idx_d = IDX_W'(i - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            idx_q  <= '0;
        end else begin
            mask_q <= mask_d;
            idx_q  <= idx_d;
        end
    end

    assign idx_o   = idx_q;
    assign empty_o = (mask_q == '0);
    assign last_o  = (remain == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Next-state engine of the multicycle 16-bit RISC core: emits the state number
// consumed by the control decoder, walks LM/SM masks and latches halt/illegal.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned STATE_W = SEQ_STATE_W,
    parameter int unsigned MASK_W  = SEQ_MASK_W
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_sequencer_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(MASK_W);

    state_e             state_q, state_d;
    logic               lsm_load, lsm_advance, set_illegal;
    logic               lsm_empty, lsm_last;
    logic [IDX_W-1:0]   lsm_idx;
    logic               done_q, inc_q, halted_q, illegal_q;
    logic [3:0]         opcode;
    logic [1:0]         cz;
    logic               unused_ir;

    assign opcode    = bus.ir[15:12];
    assign cz        = bus.ir[1:0];
    assign unused_ir = ^bus.ir[11:8];

    lsm_mask_walker #(
        .MASK_W (MASK_W),
        .IDX_W  (IDX_W)
    ) u_walker (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (lsm_load),
        .load_mask_i (bus.ir[MASK_W-1:0]),
        .advance_i   (lsm_advance),
        .idx_o       (lsm_idx),
        .empty_o     (lsm_empty),
        .last_o      (lsm_last)
    );

    always_comb begin
        state_d     = state_q;
        lsm_load    = 1'b0;
        lsm_advance = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_NDU: begin
                        case (cz)
                            CZ_ALWAYS: state_d = S_ALU_RR;
                            CZ_CARRY:  state_d = bus.carry_flag ? S_ALU_RR : S_FETCH;
                            CZ_ZERO:   state_d = bus.zero_flag  ? S_ALU_RR : S_FETCH;
                            default: begin
                                state_d     = S_HALT;
                                set_illegal = 1'b1;
                            end
                        endcase
                    end
                    OP_ADI:         state_d = S_ALU_IMM;
                    OP_LHI:         state_d = S_LHI_WB;
                    OP_LW, OP_SW:   state_d = S_ADDR;
                    OP_BEQ:         state_d = S_BEQ_CMP;
                    OP_JAL, OP_JLR: state_d = S_JAL_LINK;
                    OP_LM, OP_SM:   state_d = S_LSM_INIT;
                    OP_HLT:         state_d = S_HALT;
                    default: begin
                        state_d     = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_ALU_RR:   state_d = S_WB_RC;
            S_WB_RC:    state_d = S_FETCH;
            S_ALU_IMM:  state_d = S_WB_RB;
            S_WB_RB:    state_d = S_FETCH;
            S_LHI_WB:   state_d = S_FETCH;
            S_ADDR:     state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_WB_LW;
            S_WB_LW:    state_d = S_FETCH;
            S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
            S_BEQ_CMP:  state_d = bus.compare ? S_BEQ_TAKE : S_FETCH;
            S_BEQ_TAKE: state_d = S_FETCH;
            S_JAL_LINK: state_d = (opcode == OP_JAL) ? S_JAL_TGT : S_JLR_TGT;
            S_JAL_TGT:  state_d = S_FETCH;
            S_JLR_TGT:  state_d = S_FETCH;
            S_LSM_INIT: begin
                lsm_load = 1'b1;
                if (bus.ir[MASK_W-1:0] == '0) state_d = S_FETCH;
                else state_d = (opcode == OP_LM) ? S_LM_RD : S_SM_WR;
            end
            // An empty mask here is unreachable; bail to FETCH rather than wedge.
            S_LM_RD: begin
                if (lsm_empty) state_d = S_FETCH;
                else if (bus.mem_ready) state_d = S_LM_WB;
            end
            S_LM_WB: begin
                lsm_advance = 1'b1;
                state_d     = lsm_last ? S_FETCH : S_LM_RD;
            end
            S_SM_WR: begin
                if (lsm_empty) begin
                    state_d = S_FETCH;
                end else if (bus.mem_ready) begin
                    lsm_advance = 1'b1;
                    state_d     = lsm_last ? S_FETCH : S_SM_WR;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            done_q    <= 1'b0;
            inc_q     <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_HALT);
            inc_q     <= lsm_advance;
            halted_q  <= halted_q | (state_d == S_HALT);
            illegal_q <= illegal_q | set_illegal;
        end
    end

    assign bus.state_id     = STATE_W'(state_q);
    assign bus.lsm_reg_idx  = 3'(lsm_idx);
    assign bus.lsm_addr_inc = inc_q;
    assign bus.instr_done   = done_q;
    assign bus.halted       = halted_q;
    assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: per-instruction state paths built from the ISA rules.
module tb_instr_sequencer;

    localparam int S_FETCH = 0, S_DECODE = 1, S_ALU_RR = 2, S_WB_RC = 3, S_ALU_IMM = 4,
                   S_WB_RB = 5, S_LHI_WB = 6, S_ADDR = 7, S_MEM_RD = 8, S_WB_LW = 9,
                   S_MEM_WR = 10, S_BEQ_CMP = 11, S_BEQ_TAKE = 12, S_JAL_LINK = 13,
                   S_JAL_TGT = 14, S_JLR_TGT = 15, S_LSM_INIT = 16, S_LM_RD = 17,
                   S_LM_WB = 18, S_SM_WR = 19, S_HALT = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    instr_sequencer_if #(.STATE_W(5)) bus ();

    instr_sequencer #(.STATE_W(5), .MASK_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int exp_st[$];
    int exp_ix[$];
    bit exp_illegal;
    int exp_pulses;
    bit done_pending;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int s, input int ix);
        exp_st.push_back(s);
        exp_ix.push_back(ix);
    endtask

    function automatic bit is_mem(input int s);
        return s == S_FETCH || s == S_MEM_RD || s == S_MEM_WR || s == S_LM_RD || s == S_SM_WR;
    endfunction

    // Reference path: the stall-free sequence of states one instruction visits.
    task automatic build(input logic [15:0] ir_v, input bit c, input bit z, input bit cmp);
        logic [3:0] op;
        op = ir_v[15:12];
        exp_st.delete();
        exp_ix.delete();
        exp_illegal = 1'b0;
        exp_pulses  = 0;
        push(S_FETCH, -1);
        push(S_DECODE, -1);
        case (op)
            4'h0, 4'h2: begin
                if (ir_v[1:0] == 2'b11) begin
                    push(S_HALT, -1);
                    exp_illegal = 1'b1;
                end else if (ir_v[1:0] == 2'b00 || (ir_v[1:0] == 2'b10 && c) ||
                             (ir_v[1:0] == 2'b01 && z)) begin
                    push(S_ALU_RR, -1);
                    push(S_WB_RC, -1);
                end
            end
            4'h1: begin push(S_ALU_IMM, -1); push(S_WB_RB, -1); end
            4'h3: push(S_LHI_WB, -1);
            4'h4: begin push(S_ADDR, -1); push(S_MEM_RD, -1); push(S_WB_LW, -1); end
            4'h5: begin push(S_ADDR, -1); push(S_MEM_WR, -1); end
            4'hC: begin push(S_BEQ_CMP, -1); if (cmp) push(S_BEQ_TAKE, -1); end
            4'h8: begin push(S_JAL_LINK, -1); push(S_JAL_TGT, -1); end
            4'h9: begin push(S_JAL_LINK, -1); push(S_JLR_TGT, -1); end
            4'h6, 4'h7: begin
                push(S_LSM_INIT, -1);
                for (int i = 0; i < 8; i++) begin
                    if (ir_v[i]) begin
                        exp_pulses++;
                        if (op == 4'h6) begin
                            push(S_LM_RD, i);
                            push(S_LM_WB, i);
                        end else begin
                            push(S_SM_WR, i);
                        end
                    end
                end
            end
            4'hF: push(S_HALT, -1);
            default: begin
                push(S_HALT, -1);
                exp_illegal = 1'b1;
            end
        endcase
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(bus.state_id), 32'(S_FETCH));
        chk("rst_idx", 32'(bus.lsm_reg_idx), 32'(0));
        chk("rst_halted", 32'(bus.halted), 32'(0));
        chk("rst_illegal", 32'(bus.illegal), 32'(0));
        chk("rst_done", 32'(bus.instr_done), 32'(0));
        chk("rst_inc", 32'(bus.lsm_addr_inc), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        done_pending = 1'b0;
    endtask

    // Called at a negedge with the DUT in FETCH.
    task automatic run_one(input logic [15:0] ir_v, input bit c, input bit z, input bit cmp,
                           input int stall_pct, input int stall_state, input int stall_n);
        int pos, pulses, budget, held;
        bit first, mr, hit_halt;
        build(ir_v, c, z, cmp);
        bus.ir = ir_v;
        bus.carry_flag = c;
        bus.zero_flag = z;
        bus.compare = cmp;
        pos = 0; pulses = 0; budget = 0; held = 0; first = 1'b1; hit_halt = 1'b0;
        while (pos < exp_st.size() && budget < 400) begin
            chk("state", 32'(bus.state_id), 32'(exp_st[pos]));
            if (exp_ix[pos] >= 0) chk("lsm_idx", 32'(bus.lsm_reg_idx), 32'(exp_ix[pos]));
            chk("instr_done", 32'(bus.instr_done), 32'(pos == 0 && first && done_pending));
            chk("halted", 32'(bus.halted), 32'(exp_st[pos] == S_HALT));
            chk("illegal", 32'(bus.illegal), 32'(exp_st[pos] == S_HALT && exp_illegal));
            if (exp_st[pos] == S_HALT) begin
                hit_halt = 1'b1;
                break;
            end
            if (exp_st[pos] == stall_state && held < stall_n) begin
                mr = 1'b0;
                held++;
            end else begin
                mr = ($urandom_range(0, 99) >= stall_pct);
            end
            bus.mem_ready = mr;
            if (!(is_mem(exp_st[pos]) && !mr)) pos++;
            first = 1'b0;
            budget++;
            @(posedge clk);
            @(negedge clk);
            pulses += int'(bus.lsm_addr_inc);
        end
        if (budget >= 400) begin
            chk("cycle_budget", 32'(pos), 32'(exp_st.size()));
        end else if (hit_halt) begin
            for (int k = 0; k < 10; k++) begin
                bus.mem_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                @(negedge clk);
                chk("halt_hold", 32'(bus.state_id), 32'(S_HALT));
                chk("halted_sticky", 32'(bus.halted), 32'(1));
                chk("illegal_sticky", 32'(bus.illegal), 32'(exp_illegal));
            end
            apply_reset();
        end else begin
            chk("ret_fetch", 32'(bus.state_id), 32'(S_FETCH));
            chk("addr_inc_count", 32'(pulses), 32'(exp_pulses));
            done_pending = 1'b1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int waited;
        logic [3:0] op;
        bus.ir = '0;
        bus.compare = 1'b0;
        bus.carry_flag = 1'b0;
        bus.zero_flag = 1'b0;
        bus.mem_ready = 1'b0;
        done_pending = 1'b0;
        #1;
        apply_reset();

        run_one(16'h0050, 1'b0, 1'b0, 1'b0, 0, -1, 0);
        run_one(16'h0052, 1'b0, 1'b0, 1'b0, 0, -1, 0);
        run_one(16'h0052, 1'b1, 1'b0, 1'b0, 0, -1, 0);
        run_one(16'h2051, 1'b0, 1'b1, 1'b0, 0, -1, 0);
        run_one(16'h4000, 1'b0, 1'b0, 1'b0, 0, S_MEM_RD, 3);
        run_one(16'h5000, 1'b0, 1'b0, 1'b0, 0, S_MEM_WR, 2);
        run_one(16'h60A5, 1'b0, 1'b0, 1'b0, 0, -1, 0);
        run_one(16'h7000, 1'b0, 1'b0, 1'b0, 0, -1, 0);
        run_one(16'h70FF, 1'b0, 1'b0, 1'b0, 30, -1, 0);
        run_one(16'hC000, 1'b0, 1'b0, 1'b1, 0, -1, 0);
        run_one(16'hC000, 1'b0, 1'b0, 1'b0, 0, -1, 0);
        run_one(16'h1000, 1'b0, 1'b0, 1'b0, 0, -1, 0);
        run_one(16'h3000, 1'b0, 1'b0, 1'b0, 0, -1, 0);
        run_one(16'h8000, 1'b0, 1'b0, 1'b0, 0, -1, 0);
        run_one(16'h9000, 1'b0, 1'b0, 1'b0, 0, -1, 0);
        run_one(16'hF000, 1'b0, 1'b0, 1'b0, 0, -1, 0);
        run_one(16'hA000, 1'b0, 1'b0, 1'b0, 0, -1, 0);

        // Asynchronous reset while a load-multiple is stalled in LM_RD.
        bus.ir = 16'h60A4;
        bus.mem_ready = 1'b1;
        waited = 0;
        while (int'(bus.state_id) != S_LM_RD && waited < 20) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        chk("lm_reach", 32'(bus.state_id), 32'(S_LM_RD));
        chk("lm_idx_pre", 32'(bus.lsm_reg_idx), 32'(2));
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #2;
        apply_reset();

        for (int n = 0; n < 60; n++) begin
            op = 4'($urandom_range(0, 15));
            if ((op == 4'hA || op == 4'hB || op == 4'hD || op == 4'hE || op == 4'hF) &&
                $urandom_range(0, 2) != 0) op = 4'h0;
            run_one({op, 12'($urandom)}, 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 50), -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Next-state engine of the multicycle 16-bit RISC core.
- Consumes the instruction register, ALU compare, C/Z flags and memory ready, and produces the 5-bit state number.
- The datapath control decoder turns that state number into mux selects and enables.
- Owns the LM/SM register-mask walk, the memory-wait stalls and halt/illegal detection.

Parameters:
- STATE_W, 5, width of state_id.
- MASK_W, 8, LM/SM register-mask width (= register count).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- ir  in  16  instruction register; stable from DECODE until the next FETCH.
- compare  in  1  ALU equality result; valid in BEQ_CMP.
- carry_flag  in  1  architectural C flag.
- zero_flag  in  1  architectural Z flag.
- mem_ready  in  1  memory access completes this cycle.
- state_id  out  STATE_W  current state; direct register output.
- lsm_reg_idx  out  3  register index of the current LM/SM transfer.
- lsm_addr_inc  out  1  one-cycle pulse: datapath increments the LM/SM address.
- instr_done  out  1  one-cycle pulse on return to FETCH after an instruction.
- halted  out  1  sticky; core stopped.
- illegal  out  1  sticky; halt caused by an undefined opcode.

Behaviour:
- Reset (asynchronous): state_id=FETCH(0), mask=0, lsm_reg_idx=0, all pulses and sticky flags 0. Release is effective at the next posedge.
- State encoding (in the shared package):
  0 FETCH, 1 DECODE, 2 ALU_RR, 3 WB_RC, 4 ALU_IMM, 5 WB_RB, 6 LHI_WB, 7 ADDR, 8 MEM_RD, 9 WB_LW, 10 MEM_WR, 11 BEQ_CMP, 12 BEQ_TAKE, 13 JAL_LINK, 14 JAL_TGT, 15 JLR_TGT, 16 LSM_INIT, 17 LM_RD, 18 LM_WB, 19 SM_WR, 20 HALT.
- FETCH: hold while mem_ready=0; when mem_ready=1, go to DECODE.
- DECODE: branch on opcode = ir[15:12].
  - 0000 ADD / 0010 NDU: use cz = ir[1:0]. 00 -> ALU_RR; 10 -> ALU_RR if carry_flag else FETCH; 01 -> ALU_RR if zero_flag else FETCH; 11 -> HALT with illegal.
  - 0001 ADI -> ALU_IMM. 0011 LHI -> LHI_WB. 0100 LW and 0101 SW -> ADDR. 1100 BEQ -> BEQ_CMP. 1000 JAL -> JAL_LINK. 1001 JLR -> JAL_LINK. 0110 LM and 0111 SM -> LSM_INIT. 1111 -> HALT.
  - Any other opcode -> HALT with illegal=1.
- Simple paths:
  - ALU_RR -> WB_RC -> FETCH.
  - ALU_IMM -> WB_RB -> FETCH.
  - LHI_WB -> FETCH.
- Loads and stores:
  - ADDR -> MEM_RD (LW) or MEM_WR (SW).
  - MEM_RD and MEM_WR hold while mem_ready=0.
  - MEM_RD -> WB_LW -> FETCH. MEM_WR -> FETCH.
- Branch: BEQ_CMP -> BEQ_TAKE if compare, else FETCH. BEQ_TAKE -> FETCH.
- Jumps: JAL_LINK -> JAL_TGT (JAL) or JLR_TGT (JLR). Both -> FETCH.
- LM/SM:
  - LSM_INIT latches mask = ir[7:0]. Mask 0 -> FETCH. Otherwise -> LM_RD (LM) or SM_WR (SM).
  - lsm_reg_idx is always the lowest set bit of the live mask (combinational priority encode, registered output).
  - LM_RD holds for mem_ready, then -> LM_WB.
  - LM_WB, or SM_WR when mem_ready=1, does all of: clear the mask bit at lsm_reg_idx, pulse lsm_addr_inc, then go to FETCH if the remaining mask is 0, else LM_RD / SM_WR.
  - Mask 0xFF takes exactly 8 transfers with indices 0..7 ascending. Zero bits are skipped at no cycle cost.
- instr_done: high for exactly one cycle while state_id=FETCH when the previous state was not FETCH/HALT. Not asserted after reset or during a fetch stall.
- HALT is absorbing until reset; halted=1 from the cycle state_id=HALT.
- Reset asserted mid-LM/SM or mid-stall: immediate return to FETCH; mask cleared.
- mem_ready is ignored outside FETCH, MEM_RD, MEM_WR, LM_RD, SM_WR.

Decomposition:
- Shared package: state enum/localparams (0..20), opcode constants, cz encodings, STATE_W.
- The control decoder imports the same package.
- One sub-module: lsm_mask_walker (mask register, lowest-set-bit encoder, clear-on-advance, empty flag).

Test Plan:
- Reset mid-LM: assert rst_n=0 in LM_RD -> state_id=0, lsm_reg_idx=0, halted=0 without waiting for a clock.
- ADD unconditional, mem_ready=1 always: ir=0x0050 -> states 0,1,2,3,0; instr_done pulses once on the final FETCH.
- ADC with carry_flag=0: ir=0x0052 -> states 0,1,0; no WB_RC. With carry_flag=1 -> states 0,1,2,3,0.
- LW with mem_ready low for 3 cycles in MEM_RD: ir=0x4000 -> MEM_RD held 4 cycles total, then WB_LW, then FETCH.
- LM ir=0x60A5 (mask 1010_0101) -> lsm_reg_idx sequence 0,2,5,7; 4 lsm_addr_inc pulses; then FETCH. SM with mask 0x00 -> LSM_INIT -> FETCH.
- BEQ compare=1 -> 11,12,0; compare=0 -> 11,0. ir=0xA000 -> HALT with illegal=1 and halted=1; both hold across 10 cycles.
